// File: rtl/arb_pkg.sv
// Shared types and helpers for the FCFS request arbiter: FSM states,
// tie-break mode codes and one-hot/index conversion.
package arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest requester vector the helpers handle; callers cast to their own width.
  localparam int unsigned MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] id_to_onehot(input int unsigned id);
    return MAX_REQ'(1) << id;
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic int unsigned first_set_id(input logic [MAX_REQ-1:0] v);
    int unsigned id;
    logic [MAX_REQ-1:0] s;
    id = 0;
    for (int unsigned i = MAX_REQ; i > 0; i--) begin
      s = v >> (i - 1);
      if (s[0]) id = i - 1;
    end
    return id;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Circular-buffer queue of requester IDs; push is ignored when full and
// pop when empty, simultaneous push/pop leaves the occupancy unchanged.
module arb_id_fifo
  import arb_pkg::*;
#(
  parameter  int unsigned W     = 2,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_id,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  always_comb begin
    o_full    = (r_count == CW'(DEPTH));
    o_empty   = (r_count == '0);
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
    o_head    = r_mem[r_rd];
    o_count   = r_count;
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_push_id;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_request_arbiter.sv
// First-come-first-served arbiter: request edges are queued by arrival order
// and served as registered one-hot grants, with hold timeout and abandon skipping.
module fifo_request_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned PRIO_MODE = PRIO_FIXED,
  parameter  int unsigned MAX_HOLD  = 8,
  localparam int unsigned IDW       = $clog2(N_REQ),
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] request,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDW-1:0]   grant_id_o,
  output logic [CW-1:0]    queue_count_o,
  output logic             timeout_o
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_req_q;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_queued;
  logic [N_REQ-1:0] r_grant;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_rr;
  logic [HW-1:0]    r_hold;
  logic             r_timeout;

  logic [N_REQ-1:0] w_rise;
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_pick_oh;
  logic [N_REQ-1:0] w_head_oh;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  always_comb begin
    w_rise = request & ~r_req_q;
    w_cand = (r_pending | w_rise) & request & ~r_queued & ~r_grant;
    // Round-robin: rotate rr_ptr down to bit 0, take the lowest bit, add the offset back.
    if (PRIO_MODE == PRIO_RR) begin
      w_rot  = (w_cand >> r_rr) | (w_cand << (N_REQ - 32'(r_rr)));
      w_pick = IDW'((first_set_id(MAX_REQ'(w_rot)) + 32'(r_rr)) % N_REQ);
    end else begin
      w_rot  = w_cand;
      w_pick = IDW'(first_set_id(MAX_REQ'(w_rot)));
    end
    w_pick_oh = N_REQ'(id_to_onehot(32'(w_pick)));
    w_head_oh = N_REQ'(id_to_onehot(32'(w_head)));
    w_push    = (|w_cand) && !w_full;
    w_pop     = (r_state == ST_IDLE) && !w_empty;
  end

  arb_id_fifo #(
    .W     (IDW),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_push    (w_push),
    .i_push_id (w_pick),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req_q    <= '0;
      r_pending  <= '0;
      r_queued   <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr       <= '0;
      r_hold     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_req_q   <= request;
      r_pending <= w_cand & ~(w_push ? w_pick_oh : '0);
      r_queued  <= (r_queued & ~(w_pop ? w_head_oh : '0)) | (w_push ? w_pick_oh : '0);
      r_timeout <= 1'b0;
      if (w_push && PRIO_MODE == PRIO_RR)
        r_rr <= (w_pick == IDW'(N_REQ - 1)) ? '0 : w_pick + 1'b1;

      case (r_state)
        ST_IDLE: begin
          // A popped entry whose requester has already dropped is discarded.
          if (w_pop && request[w_head]) begin
            r_grant    <= w_head_oh;
            r_grant_id <= w_head;
            r_hold     <= HW'(1);
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!request[r_grant_id]) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_state    <= ST_IDLE;
          end else if (MAX_HOLD != 0 && r_hold == HW'(MAX_HOLD)) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_timeout  <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (MAX_HOLD != 0) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign grant_valid_o = |r_grant;
  assign grant_id_o    = r_grant_id;
  assign queue_count_o = w_count;
  assign timeout_o     = r_timeout;

endmodule
